// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and helpers for the multiply/divide sequencer.
// Pure declarations; no timing or flow control of its own.
package mdu_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   localparam int DEF_CNT_W    = 4;

   function automatic logic is_start_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_mult_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply/divide producing the full {hi,lo} result; zero latency.
// No flow control; a divide by zero returns the current hi/lo so completion leaves them intact.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  md_op_i,
   input  logic [31:0] rs_val_i,
   input  logic [31:0] rt_val_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [31:0] res_hi_o,
   output logic [31:0] res_lo_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;
   logic [31:0] uq, ur;
   logic        rt_zero;

   assign prod_s  = {{32{rs_val_i[31]}}, rs_val_i} * {{32{rt_val_i[31]}}, rt_val_i};
   assign prod_u  = {32'd0, rs_val_i} * {32'd0, rt_val_i};
   assign rt_zero = (rt_val_i == 32'd0);

   // Signed divide on magnitudes: 0x80000000 / -1 wraps back to 0x80000000 naturally.
   assign a_mag = rs_val_i[31] ? (32'd0 - rs_val_i) : rs_val_i;
   assign b_mag = rt_val_i[31] ? (32'd0 - rt_val_i) : rt_val_i;
   assign q_mag = rt_zero ? 32'd0 : a_mag / b_mag;
   assign r_mag = rt_zero ? 32'd0 : a_mag % b_mag;
   assign q_s   = (rs_val_i[31] ^ rt_val_i[31]) ? (32'd0 - q_mag) : q_mag;
   assign r_s   = rs_val_i[31] ? (32'd0 - r_mag) : r_mag;
   assign uq    = rt_zero ? 32'd0 : rs_val_i / rt_val_i;
   assign ur    = rt_zero ? 32'd0 : rs_val_i % rt_val_i;

   always_comb begin
      res_hi_o = hi_i;
      res_lo_o = lo_i;
      case (md_op_i)
         MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
         MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
         MD_DIV: begin
            if (!rt_zero) begin
               res_hi_o = r_s;
               res_lo_o = q_s;
            end
         end
         MD_DIVU: begin
            if (!rt_zero) begin
               res_hi_o = ur;
               res_lo_o = uq;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and mult/div sequencer; results land MULT_LAT/DIV_LAT cycles after start.
// Stalls the D-stage md op while a start is issuing or an operation is in flight.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        start,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      res_hi, res_lo;

   mdu_arith u_arith (
      .md_op_i  (md_op),
      .rs_val_i (rs_val),
      .rt_val_i (rt_val),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .res_hi_o (res_hi),
      .res_lo_o (res_lo)
   );

   assign start     = op_valid & is_start_op(md_op) & (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign stall_req = d_is_md & (start | busy);
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      rdata = 32'd0;
      if (md_op == MD_MFHI)      rdata = hi_q;
      else if (md_op == MD_MFLO) rdata = lo_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               cnt_d     = is_mult_op(md_op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
            end else if (op_valid && md_op == MD_MTHI) begin
               hi_d = rs_val;
            end else if (op_valid && md_op == MD_MTLO) begin
               lo_d = rs_val;
            end
         end
         S_RUN: begin
            // Issue attempts here are ignored; the hazard unit should have stalled them.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, divide-by-zero hold, stall, reset abort.
module tb_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
   logic        busy;
   logic        start;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   int vec_cnt = 0;
   int err_cnt = 0;

   mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .md_op     (md_op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .d_is_md   (d_is_md),
      .busy      (busy),
      .start     (start),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo),
      .rdata     (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a start op for one cycle; returns in cycle T+1 with inputs idle.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      md_op    = op;
      rs_val   = a;
      rt_val   = b;
      #1;
      chk("start_on_issue", {31'd0, start}, 32'd1);
      step();
      op_valid = 1'b0;
      md_op    = OP_NONE;
      #1;
   endtask

   // Checks n busy cycles with HI/LO still holding their pre-operation values.
   task automatic run_cycles(input int n, input logic [31:0] ehi, input logic [31:0] elo);
      for (int i = 0; i < n; i++) begin
         chk("busy_run", {31'd0, busy}, 32'd1);
         chk("hi_hold", hi, ehi);
         chk("lo_hold", lo, elo);
         step();
      end
   endtask

   initial begin
      reset    = 1'b0;
      op_valid = 1'b0;
      md_op    = OP_NONE;
      rs_val   = 32'd0;
      rt_val   = 32'd0;
      d_is_md  = 1'b0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      #10 reset = 1'b1;
      step();

      // MULT -2*3 with a D-stage md op held: stall through T..T+5, released at T+6
      d_is_md = 1'b1;
      op_valid = 1'b1; md_op = OP_MULT; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
      #1;
      chk("mult_stall_T", {31'd0, stall_req}, 32'd1);
      chk("mult_start", {31'd0, start}, 32'd1);
      step();
      op_valid = 1'b0; md_op = OP_NONE;
      #1;
      for (int i = 1; i <= 5; i++) begin
         chk("mult_stall_run", {31'd0, stall_req}, 32'd1);
         chk("mult_busy", {31'd0, busy}, 32'd1);
         chk("mult_hi_hold", hi, 32'd0);
         step();
      end
      chk("mult_busy_done", {31'd0, busy}, 32'd0);
      chk("mult_stall_done", {31'd0, stall_req}, 32'd0);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFFA);
      op_valid = 1'b1; md_op = OP_MFLO;
      #1;
      chk("mflo_rdata", rdata, 32'hFFFFFFFA);
      md_op = OP_MFHI;
      #1;
      chk("mfhi_rdata", rdata, 32'hFFFFFFFF);
      op_valid = 1'b0; md_op = OP_NONE; d_is_md = 1'b0;
      #1;
      chk("rdata_none", rdata, 32'd0);

      // MULTU back-to-back in the first IDLE cycle
      issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
      chk("stall_no_d", {31'd0, stall_req}, 32'd0);
      run_cycles(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      chk("multu_busy_done", {31'd0, busy}, 32'd0);
      chk("multu_hi", hi, 32'h00000002);
      chk("multu_lo", lo, 32'hFFFFFFFA);

      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      run_cycles(10, 32'h00000002, 32'hFFFFFFFA);
      chk("div_busy_done", {31'd0, busy}, 32'd0);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("div_lo", lo, 32'hFFFFFFFD);

      issue(OP_DIVU, 32'd7, 32'd2);
      run_cycles(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);

      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_cycles(10, 32'd1, 32'd3);
      chk("divovf_hi", hi, 32'd0);
      chk("divovf_lo", lo, 32'h80000000);

      // MTHI then divide by zero: full DIV latency, HI/LO untouched
      op_valid = 1'b1; md_op = OP_MTHI; rs_val = 32'h12345678;
      #1;
      chk("mthi_no_start", {31'd0, start}, 32'd0);
      step();
      op_valid = 1'b0; md_op = OP_NONE;
      #1;
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_lo", lo, 32'h80000000);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      issue(OP_DIV, 32'd99, 32'd0);
      run_cycles(10, 32'h12345678, 32'h80000000);
      chk("div0_busy_done", {31'd0, busy}, 32'd0);
      chk("div0_hi", hi, 32'h12345678);
      chk("div0_lo", lo, 32'h80000000);

      // MULT 5*7 with a protocol-violating MULT at T+3
      issue(OP_MULT, 32'd5, 32'd7);
      run_cycles(2, 32'h12345678, 32'h80000000);
      op_valid = 1'b1; md_op = OP_MULT; rs_val = 32'd100; rt_val = 32'd100;
      #1;
      chk("illegal_no_start", {31'd0, start}, 32'd0);
      chk("illegal_busy", {31'd0, busy}, 32'd1);
      step();
      op_valid = 1'b0; md_op = OP_NONE;
      #1;
      run_cycles(2, 32'h12345678, 32'h80000000);
      chk("illegal_busy_done", {31'd0, busy}, 32'd0);
      chk("illegal_hi", hi, 32'd0);
      chk("illegal_lo", lo, 32'h00000023);

      // Undefined opcode and MTLO without op_valid have no effect
      op_valid = 1'b1; md_op = 4'd9; rs_val = 32'hDEADBEEF;
      #1;
      chk("op9_rdata", rdata, 32'd0);
      chk("op9_start", {31'd0, start}, 32'd0);
      step();
      op_valid = 1'b0; md_op = OP_MTLO;
      step();
      md_op = OP_NONE;
      #1;
      chk("noop_busy", {31'd0, busy}, 32'd0);
      chk("noop_hi", hi, 32'd0);
      chk("noop_lo", lo, 32'h00000023);

      // Reset at T+2 of a DIV abandons it
      issue(OP_DIV, 32'd100, 32'd3);
      step();
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      #2 reset = 1'b1;
      step();
      chk("abort_after_busy", {31'd0, busy}, 32'd0);
      op_valid = 1'b1; md_op = OP_MTLO; rs_val = 32'd5;
      step();
      op_valid = 1'b0; md_op = OP_NONE;
      #1;
      chk("mtlo_lo", lo, 32'd5);
      chk("mtlo_hi", hi, 32'd0);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
